// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - Mini-SRC control strobe bundle between control_unit and Datapath
interface control_unit_if;
   logic [31:0] IR;
   logic        CON_FF;
   logic        stop;
   logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
   logic        MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, Rin, CONin;
   logic        Gra, Grb, Grc, IncPC, Read, Write;
   logic        Run;
   logic [3:0]  step;

   modport master (
      input  IR, CON_FF, stop,
      output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
      output MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, Rin, CONin,
      output Gra, Grb, Grc, IncPC, Read, Write, Run, step
   );

   modport slave (
      output IR, CON_FF, stop,
      input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
      input  MARin, PCin, MDRin, IRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, Rin, CONin,
      input  Gra, Grb, Grc, IncPC, Read, Write, Run, step
   );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Mini-SRC control sequencer: fetch, decode and execute strobes for Datapath
module control_unit #(
   parameter int unsigned MEM_WAIT = 0
) (
   input logic            clock,
   input logic            clear,
   control_unit_if.master bus
);
   localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

   typedef enum logic [3:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_RESET, S_HALT
   } state_t;

   localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_MUL = 5'd15, OP_DIV = 5'd16;
   localparam logic [4:0] OP_NEG = 5'd17, OP_NOT = 5'd18, OP_BR = 5'd19, OP_JR = 5'd20, OP_IN = 5'd22;
   localparam logic [4:0] OP_OUT = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_HALT = 5'd27;

   state_t        state_q, state_d, boundary;
   logic [4:0]    op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          is_alu, is_imm, is_ldi, is_ld, is_st, is_md, is_nn, is_br, is_wait;
   logic          unused_ir;

   assign unused_ir = ^bus.IR[26:0];
   assign is_alu = (op_q >= 5'd3) && (op_q <= 5'd11);
   assign is_imm = (op_q >= 5'd12) && (op_q <= 5'd14);
   assign is_ldi = (op_q == OP_LDI);
   assign is_ld  = (op_q == OP_LD);
   assign is_st  = (op_q == OP_ST);
   assign is_md  = (op_q == OP_MUL) || (op_q == OP_DIV);
   assign is_nn  = (op_q == OP_NEG) || (op_q == OP_NOT);
   assign is_br  = (op_q == OP_BR);
   // Memory steps hold until the wait counter drains
   assign is_wait = (state_q == S_T1) || ((state_q == S_T6) && is_ld) || ((state_q == S_T7) && is_st);

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_RESET;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = (state_q == S_T2) ? bus.IR[31:27] : op_q;
      cnt_d    = CW'(MEM_WAIT);
      boundary = bus.stop ? S_HALT : S_T0;
      if (is_wait && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         case (state_q)
            S_RESET: state_d = boundary;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3: begin
               if (op_q == OP_HALT) state_d = S_HALT;
               else if (is_alu || is_imm || is_ldi || is_ld || is_st || is_md || is_nn || is_br) state_d = S_T4;
               else state_d = boundary;
            end
            S_T4:    state_d = is_nn ? boundary : S_T5;
            S_T5:    state_d = (is_ld || is_st || is_md || is_br) ? S_T6 : boundary;
            S_T6:    state_d = (is_ld || is_st) ? S_T7 : boundary;
            S_T7:    state_d = boundary;
            default: state_d = S_HALT;
         endcase
      end
   end

   always_comb begin
      bus.PCout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0; bus.HIout = 1'b0;
      bus.LOout = 1'b0; bus.InPortout = 1'b0; bus.Cout = 1'b0; bus.BAout = 1'b0; bus.Rout = 1'b0;
      bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
      bus.Zhighin = 1'b0; bus.Zlowin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0; bus.OutPortin = 1'b0;
      bus.Rin = 1'b0; bus.CONin = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
      bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
      bus.Run  = (state_q != S_RESET) && (state_q != S_HALT);
      bus.step = bus.Run ? {1'b0, state_q[2:0]} : 4'hF;
      case (state_q)
         S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.PCin = 1'b1; end
         S_T1: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
         S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
         S_T3: begin
            if (is_alu || is_imm) begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            if (is_ldi || is_ld || is_st) begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
            if (is_md) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
            if (is_nn) begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; end
            if (is_br) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
            if (op_q == OP_JR) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            if (op_q == OP_IN) begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (op_q == OP_OUT) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
            if (op_q == OP_MFHI) begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (op_q == OP_MFLO) begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
         end
         S_T4: begin
            if (is_alu) begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; end
            if (is_imm || is_ldi || is_ld || is_st) begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
            if (is_md) begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zlowin = 1'b1; bus.Zhighin = 1'b1; end
            if (is_nn) begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (is_br) begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
         end
         S_T5: begin
            if (is_alu || is_imm || is_ldi) begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (is_ld || is_st) begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
            if (is_md) begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
            if (is_br) begin bus.Cout = 1'b1; bus.Zlowin = 1'b1; end
         end
         S_T6: begin
            if (is_ld) begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
            if (is_st) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
            if (is_md) begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
            // Branch taken only when the condition flop is set; otherwise the step is idle
            if (is_br && bus.CON_FF) begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; end
         end
         S_T7: begin
            if (is_ld) begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            if (is_st) bus.Write = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against a step-table model
module tb_control_unit;
   localparam int MW = 2;

   localparam logic [27:0] PCOUT = 28'h1 << 0,  ZHOUT = 28'h1 << 1,  ZLOUT = 28'h1 << 2,  MDROUT = 28'h1 << 3;
   localparam logic [27:0] HIOUT = 28'h1 << 4,  LOOUT = 28'h1 << 5,  INPOUT = 28'h1 << 6, COUT = 28'h1 << 7;
   localparam logic [27:0] BAOUT = 28'h1 << 8,  ROUT = 28'h1 << 9,   MARIN = 28'h1 << 10, PCIN = 28'h1 << 11;
   localparam logic [27:0] MDRIN = 28'h1 << 12, IRIN = 28'h1 << 13,  YIN = 28'h1 << 14,   ZHIN = 28'h1 << 15;
   localparam logic [27:0] ZLIN = 28'h1 << 16,  HIIN = 28'h1 << 17,  LOIN = 28'h1 << 18,  OUTPIN = 28'h1 << 19;
   localparam logic [27:0] RIN = 28'h1 << 20,   CONIN = 28'h1 << 21, GRA = 28'h1 << 22,   GRB = 28'h1 << 23;
   localparam logic [27:0] GRC = 28'h1 << 24,   INCPC = 28'h1 << 25, READ = 28'h1 << 26,  WRITE = 28'h1 << 27;
   localparam logic [31:0] ADD = 32'h18918000;

   typedef struct packed { logic [3:0] step; logic [27:0] m; } exp_t;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];

   control_unit_if cu();
   control_unit #(.MEM_WAIT(MW)) dut (.clock(clock), .clear(clear), .bus(cu));

   always #5 clock = ~clock;

   function automatic logic [27:0] strobes();
      return {cu.Write, cu.Read, cu.IncPC, cu.Grc, cu.Grb, cu.Gra, cu.CONin, cu.Rin, cu.OutPortin,
              cu.LOin, cu.HIin, cu.Zlowin, cu.Zhighin, cu.Yin, cu.IRin, cu.MDRin, cu.PCin, cu.MARin,
              cu.Rout, cu.BAout, cu.Cout, cu.InPortout, cu.LOout, cu.HIout, cu.MDRout, cu.Zlowout,
              cu.Zhighout, cu.PCout};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic push(input int s, input logic [27:0] m, input bit mem);
      repeat (mem ? MW + 1 : 1) exp_q.push_back({4'(s), m});
   endtask

   // Expected per-cycle (step, strobe set) list for one whole instruction
   task automatic model(input logic [31:0] ir, input bit con);
      logic [4:0] op;
      op = ir[31:27];
      exp_q.delete();
      push(0, PCOUT | MARIN | INCPC | PCIN, 0);
      push(1, READ | MDRIN, 1);
      push(2, MDROUT | IRIN, 0);
      case (op) inside
         [5'd3:5'd11]: begin
            push(3, GRB | ROUT | YIN, 0); push(4, GRC | ROUT | ZLIN, 0); push(5, ZLOUT | GRA | RIN, 0);
         end
         [5'd12:5'd14]: begin
            push(3, GRB | ROUT | YIN, 0); push(4, COUT | ZLIN, 0); push(5, ZLOUT | GRA | RIN, 0);
         end
         5'd0, 5'd1, 5'd2: begin
            push(3, GRB | BAOUT | YIN, 0); push(4, COUT | ZLIN, 0);
            if (op == 5'd1) push(5, ZLOUT | GRA | RIN, 0);
            else begin
               push(5, ZLOUT | MARIN, 0);
               if (op == 5'd0) begin push(6, READ | MDRIN, 1); push(7, MDROUT | GRA | RIN, 0); end
               else begin push(6, GRA | ROUT | MDRIN, 0); push(7, WRITE, 1); end
            end
         end
         5'd15, 5'd16: begin
            push(3, GRA | ROUT | YIN, 0); push(4, GRB | ROUT | ZLIN | ZHIN, 0);
            push(5, ZLOUT | LOIN, 0); push(6, ZHOUT | HIIN, 0);
         end
         5'd17, 5'd18: begin push(3, GRB | ROUT | ZLIN, 0); push(4, ZLOUT | GRA | RIN, 0); end
         5'd19: begin
            push(3, GRA | ROUT | CONIN, 0); push(4, PCOUT | YIN, 0); push(5, COUT | ZLIN, 0);
            push(6, con ? (ZLOUT | PCIN) : 28'h0, 0);
         end
         5'd20: push(3, GRA | ROUT | PCIN, 0);
         5'd22: push(3, INPOUT | GRA | RIN, 0);
         5'd23: push(3, GRA | ROUT | OUTPIN, 0);
         5'd24: push(3, HIOUT | GRA | RIN, 0);
         5'd25: push(3, LOOUT | GRA | RIN, 0);
         default: push(3, 28'h0, 0);
      endcase
   endtask

   // Entered at a negedge with the DUT in T0; leaves at the negedge after the last step
   task automatic run_instr(input logic [31:0] ir, input bit con, input bit stp, input int abort_step);
      model(ir, con);
      cu.IR = ir; cu.CON_FF = con; cu.stop = stp;
      foreach (exp_q[i]) begin
         check($sformatf("op%0d_e%0d_step", ir[31:27], i), 32'(cu.step), 32'(exp_q[i].step));
         check($sformatf("op%0d_e%0d_strb", ir[31:27], i), 32'(strobes()), 32'(exp_q[i].m));
         check($sformatf("op%0d_e%0d_run", ir[31:27], i), 32'(cu.Run), 32'd1);
         if (int'(exp_q[i].step) == abort_step) return;
         @(posedge clock); @(negedge clock);
      end
   endtask

   task automatic check_halt(input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("halt%0d_step", i), 32'(cu.step), 32'hF);
         check($sformatf("halt%0d_run", i), 32'(cu.Run), 32'd0);
         check($sformatf("halt%0d_strb", i), 32'(strobes()), 32'd0);
         @(posedge clock); @(negedge clock);
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      #1;
      check("clr_strb", 32'(strobes()), 32'd0);
      check("clr_step", 32'(cu.step), 32'hF);
      @(posedge clock); @(negedge clock);
      clear = 1'b0;
      check("clr_rel_step", 32'(cu.step), 32'hF);
      @(posedge clock); @(negedge clock);
      check("restart_t0", 32'(cu.step), 32'd0);
   endtask

   task automatic measure(input logic [31:0] ir, output int cyc, output int reads);
      cu.IR = ir; cu.CON_FF = 1'b0; cu.stop = 1'b0;
      cyc = 0; reads = 0;
      do begin
         if (cu.Read) reads++;
         cyc++;
         @(posedge clock); @(negedge clock);
      end while (cu.step != 4'd0 && cyc < 50);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, reads;
      logic [4:0] op;
      cu.IR = '0; cu.CON_FF = 1'b0; cu.stop = 1'b0;
      repeat (3) @(negedge clock);
      check("reset_step", 32'(cu.step), 32'hF);
      check("reset_run", 32'(cu.Run), 32'd0);
      check("reset_strb", 32'(strobes()), 32'd0);
      clear = 1'b0;
      check("release_step", 32'(cu.step), 32'hF);
      @(posedge clock); @(negedge clock);
      check("t0_step", 32'(cu.step), 32'd0);
      check("t0_run", 32'(cu.Run), 32'd1);
      check("t0_strb", 32'(strobes()), 32'(PCOUT | MARIN | INCPC | PCIN));

      run_instr(ADD, 1'b0, 1'b0, -1);
      run_instr(32'h9A000023, 1'b1, 1'b0, -1);
      run_instr(32'h9A000023, 1'b0, 1'b0, -1);

      measure(32'h00800005, cyc, reads);
      check("ld_cycles", 32'(cyc), 32'd12);
      check("ld_read_cycles", 32'(reads), 32'd6);
      measure(32'h10800005, cyc, reads);
      check("st_cycles", 32'(cyc), 32'd12);
      run_instr(32'h00800005, 1'b0, 1'b0, -1);

      for (int k = 0; k < 40; k++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), 1'b0, -1);
      end

      run_instr(32'h10800002, 1'b0, 1'b0, 5);
      clear = 1'b1;
      #1;
      check("abort_strb", 32'(strobes()), 32'd0);
      check("abort_step", 32'(cu.step), 32'hF);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); @(negedge clock);
         check($sformatf("abort_write%0d", i), 32'(cu.Write), 32'd0);
      end
      clear = 1'b0;
      @(posedge clock); @(negedge clock);
      run_instr(ADD, 1'b0, 1'b0, -1);

      run_instr(ADD, 1'b0, 1'b1, -1);
      check_halt(5);
      cu.stop = 1'b0;
      do_clear();

      run_instr(32'hD8000000, 1'b0, 1'b0, -1);
      check_halt(20);
      do_clear();
      run_instr(ADD, 1'b0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
